// File: rtl/partial_sum_pkg.sv
// partial_sum_pkg: shared FSM state type, width helpers and saturating conversion
package partial_sum_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_e;

  function automatic int sum_w(input int in_w, input int mac);
    return in_w + $clog2(mac);
  endfunction

  function automatic int acc_w(input int in_w, input int mac, input int cnt_w);
    return sum_w(in_w, mac) + cnt_w;
  endfunction

  function automatic logic signed [63:0] sat_conv(input logic signed [63:0] v, input int ow);
    logic signed [63:0] hi;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    return v > hi ? hi : v < -hi - 64'sd1 ? -hi - 64'sd1 : v;
  endfunction

endpackage

// File: rtl/partial_sum_acc_if.sv
// partial_sum_acc_if: control, input-beat and result handshakes of the partial-sum accumulator
interface partial_sum_acc_if #(
  parameter int CHANNEL_NUM = 128,
  parameter int MACRO_NUM   = 4,
  parameter int IN_WIDTH    = 4,
  parameter int OUT_WIDTH   = 8,
  parameter int CNT_W       = 4
);
  logic                                           acc_clr;
  logic [CNT_W-1:0]                               acc_len;
  logic                                           data_in_valid;
  logic                                           data_in_ready;
  logic [CHANNEL_NUM-1:0][MACRO_NUM-1:0][IN_WIDTH-1:0] data_in;
  logic                                           data_out_valid;
  logic                                           data_out_ready;
  logic [CHANNEL_NUM-1:0][OUT_WIDTH-1:0]          data_out;

  modport master (
    output acc_clr, acc_len, data_in_valid, data_in, data_out_ready,
    input  data_in_ready, data_out_valid, data_out
  );

  modport slave (
    input  acc_clr, acc_len, data_in_valid, data_in, data_out_ready,
    output data_in_ready, data_out_valid, data_out
  );
endinterface

// File: rtl/partial_sum_tree.sv
// partial_sum_tree: MACRO_NUM-input signed adder with registered, enabled, clearable output
module partial_sum_tree
  import partial_sum_pkg::*;
#(
  parameter int MACRO_NUM = 4,
  parameter int IN_WIDTH  = 4,
  localparam int SUM_W    = sum_w(IN_WIDTH, MACRO_NUM)
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               clr,
  input  logic                               en,
  input  logic [MACRO_NUM-1:0][IN_WIDTH-1:0] d,
  output logic signed [SUM_W-1:0]            q
);

  logic signed [SUM_W-1:0] s;

  // sign-extend every macro term and add them all
  always_comb begin
    s = '0;
    for (int m = 0; m < MACRO_NUM; m++) s = s + SUM_W'($signed(d[m]));
  end

  // register the sum only for accepted beats; flush drops it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) q <= '0;
    else if (clr) q <= '0;
    else if (en) q <= s;
  end

endmodule

// File: rtl/partial_sum_acc.sv
// partial_sum_acc: per-channel beat accumulation of macro partial sums; PARTIAL_SUM_SAT_EN selects saturating output
module partial_sum_acc
  import partial_sum_pkg::*;
#(
  parameter int CHANNEL_NUM = 128,
  parameter int MACRO_NUM   = 4,
  parameter int IN_WIDTH    = 4,
  parameter int OUT_WIDTH   = 8,
  parameter int CNT_W       = 4
) (
  input logic              clk,
  input logic              rstn,
  partial_sum_acc_if.slave bus
);

  localparam int SUM_W = sum_w(IN_WIDTH, MACRO_NUM);
  localparam int ACC_W = acc_w(IN_WIDTH, MACRO_NUM, CNT_W);

  state_e                                state;
  logic [CNT_W-1:0]                      len_q;
  logic [CNT_W-1:0]                      beat_cnt;
  logic                                  sum_vld;
  logic                                  sum_first;
  logic                                  out_valid;
  logic                                  accept;
  logic signed [SUM_W-1:0]               sum     [CHANNEL_NUM];
  logic signed [ACC_W-1:0]               acc     [CHANNEL_NUM];
  logic signed [ACC_W-1:0]               acc_nxt [CHANNEL_NUM];
  logic [OUT_WIDTH-1:0]                  cv      [CHANNEL_NUM];
  logic [CHANNEL_NUM-1:0][OUT_WIDTH-1:0] out_q;

  assign bus.data_in_ready  = (state == IDLE) || (state == ACCUM);
  assign bus.data_out_valid = out_valid;
  assign bus.data_out       = out_q;
  assign accept             = bus.data_in_valid && bus.data_in_ready && !bus.acc_clr;

  for (genvar c = 0; c < CHANNEL_NUM; c++) begin : g_ch
    partial_sum_tree #(.MACRO_NUM(MACRO_NUM), .IN_WIDTH(IN_WIDTH)) u_tree (
      .clk  (clk),
      .rstn (rstn),
      .clr  (bus.acc_clr),
      .en   (accept),
      .d    (bus.data_in[c]),
      .q    (sum[c])
    );
  end

  // next accumulator value: first beat of a group loads, later beats add; then output conversion
  always_comb begin
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      acc_nxt[i] = sum_first ? ACC_W'(sum[i]) : acc[i] + ACC_W'(sum[i]);
`ifdef PARTIAL_SUM_SAT_EN
      cv[i] = OUT_WIDTH'(sat_conv(64'(acc_nxt[i]), OUT_WIDTH));
`else
      cv[i] = OUT_WIDTH'(acc_nxt[i]);
`endif
    end
  end

  // group sequencing: beat counting, pipeline tags, result valid
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      len_q     <= '0;
      beat_cnt  <= '0;
      sum_vld   <= 1'b0;
      sum_first <= 1'b0;
      out_valid <= 1'b0;
    end else if (bus.acc_clr) begin
      state     <= IDLE;
      len_q     <= '0;
      beat_cnt  <= '0;
      sum_vld   <= 1'b0;
      sum_first <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      sum_vld   <= accept;
      sum_first <= accept && (state == IDLE);
      case (state)
        IDLE: if (accept) begin
          len_q    <= bus.acc_len;
          beat_cnt <= CNT_W'(1);
          state    <= (bus.acc_len == '0) ? DRAIN : ACCUM;
        end
        ACCUM: if (accept) begin
          beat_cnt <= beat_cnt + 1'b1;
          if (beat_cnt == len_q) state <= DRAIN;
        end
        DRAIN: begin
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: if (bus.data_out_ready) begin
          out_valid <= 1'b0;
          beat_cnt  <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // accumulators follow the registered tree sums
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) for (int i = 0; i < CHANNEL_NUM; i++) acc[i] <= '0;
    else if (bus.acc_clr) for (int i = 0; i < CHANNEL_NUM; i++) acc[i] <= '0;
    else if (sum_vld) for (int i = 0; i < CHANNEL_NUM; i++) acc[i] <= acc_nxt[i];
  end

  // result register captures the final accumulate in DRAIN; flush leaves it untouched
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) out_q <= '0;
    else if (!bus.acc_clr && state == DRAIN) for (int i = 0; i < CHANNEL_NUM; i++) out_q[i] <= cv[i];
  end

endmodule

// File: tb/tb_partial_sum_acc.sv
// tb_partial_sum_acc: table-driven and randomized checks of partial_sum_acc against a sum-of-beats model
module tb_partial_sum_acc;

  localparam int CH  = 128;
  localparam int MAC = 4;
  localparam int IW  = 4;
  localparam int OW  = 8;
  localparam int CW  = 4;

  typedef struct {
    int len;
    int gap;
    int hold;
    int rnd;
    int val;
    int exp_out;
  } vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   exp_sum [CH];
  int   last_exp [CH];
  int   bv [CH][MAC];
  vec_t tbl [4];
  vec_t rv;

  always #5 clk = ~clk;

  partial_sum_acc_if #(.CHANNEL_NUM(CH), .MACRO_NUM(MAC), .IN_WIDTH(IW), .OUT_WIDTH(OW), .CNT_W(CW)) bus ();

  partial_sum_acc #(.CHANNEL_NUM(CH), .MACRO_NUM(MAC), .IN_WIDTH(IW), .OUT_WIDTH(OW), .CNT_W(CW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  function automatic int conv(input int v);
    int lim = 1 << (OW - 1);
`ifdef PARTIAL_SUM_SAT_EN
    return v >= lim ? lim - 1 : v < -lim ? -lim : v;
`else
    int w = ((v % (2 * lim)) + 2 * lim) % (2 * lim);
    return w >= lim ? w - 2 * lim : w;
`endif
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input int ex[CH]);
    int c0 = 0;
    for (int c = CH - 1; c >= 0; c--)
      if (int'($signed(bus.data_out[c])) != ex[c]) c0 = c;
    chk($sformatf("%s[ch%0d]", nm, c0), int'($signed(bus.data_out[c0])), ex[c0]);
  endtask

  task automatic fill(input int rnd, input int val);
    for (int c = 0; c < CH; c++)
      for (int m = 0; m < MAC; m++) begin
        bv[c][m] = rnd ? int'($urandom_range(15, 0)) - 8 : val;
        bus.data_in[c][m] = IW'(bv[c][m]);
      end
  endtask

  task automatic send_beat();
    int n = 0;
    bus.data_in_valid = 1'b1;
    while (!bus.data_in_ready && n < 64) begin
      step();
      n++;
    end
    if (n >= 64) chk("accept_wait", n, 0);
    step();
    bus.data_in_valid = 1'b0;
    for (int c = 0; c < CH; c++)
      for (int m = 0; m < MAC; m++) exp_sum[c] += bv[c][m];
  endtask

  task automatic run_group(input string nm, input vec_t v);
    int ex [CH];
    for (int c = 0; c < CH; c++) exp_sum[c] = 0;
    for (int b = 0; b <= v.len; b++) begin
      fill(v.rnd, v.val);
      bus.acc_len = (b == 0) ? CW'(v.len) : CW'($urandom);
      send_beat();
      if (b < v.len) repeat (v.gap) step();
    end
    for (int c = 0; c < CH; c++) ex[c] = v.rnd ? conv(exp_sum[c]) : v.exp_out;
    chk({nm, "_valid_t1"}, int'(bus.data_out_valid), 0);
    chk({nm, "_ready_t1"}, int'(bus.data_in_ready), 0);
    bus.data_out_ready = (v.hold == 0);
    step();
    chk({nm, "_valid_t2"}, int'(bus.data_out_valid), 1);
    chk_out({nm, "_out"}, ex);
    for (int k = 0; k < v.hold; k++) begin
      fill(1, 0);
      bus.data_in_valid = 1'b1;
      step();
      chk({nm, "_hold_valid"}, int'(bus.data_out_valid), 1);
      chk({nm, "_hold_ready"}, int'(bus.data_in_ready), 0);
      chk_out({nm, "_hold_out"}, ex);
    end
    bus.data_in_valid = 1'b0;
    bus.data_out_ready = 1'b1;
    step();
    chk({nm, "_post_valid"}, int'(bus.data_out_valid), 0);
    chk({nm, "_post_ready"}, int'(bus.data_in_ready), 1);
    last_exp = ex;
  endtask

  initial begin
    int zero [CH];
    for (int c = 0; c < CH; c++) zero[c] = 0;
    bus.acc_clr = 1'b0;
    bus.acc_len = '0;
    bus.data_in_valid = 1'b0;
    bus.data_in = '0;
    bus.data_out_ready = 1'b1;
    #2 rstn = 1'b0;
    #1;
    chk("rst_valid", int'(bus.data_out_valid), 0);
    chk("rst_ready", int'(bus.data_in_ready), 1);
    chk_out("rst_out", zero);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    step();

    tbl[0] = '{0, 0, 0, 0, 3, 12};
    tbl[1] = '{3, 1, 0, 0, 7, 112};
`ifdef PARTIAL_SUM_SAT_EN
    tbl[2] = '{7, 0, 0, 0, 7, 127};
    tbl[3] = '{4, 0, 5, 0, -8, -128};
`else
    tbl[2] = '{7, 0, 0, 0, 7, -32};
    tbl[3] = '{4, 0, 5, 0, -8, 96};
`endif
    for (int i = 0; i < 4; i++) run_group($sformatf("tbl%0d", i), tbl[i]);

    for (int i = 0; i < 6; i++) begin
      rv = '{int'($urandom_range(15, 0)), int'($urandom_range(2, 0)), int'($urandom_range(3, 0)), 1, 0, 0};
      run_group($sformatf("rnd%0d", i), rv);
    end

    fill(0, 5);
    bus.acc_len = CW'(3);
    send_beat();
    send_beat();
    fill(0, 6);
    bus.data_in_valid = 1'b1;
    bus.acc_clr = 1'b1;
    step();
    bus.acc_clr = 1'b0;
    bus.data_in_valid = 1'b0;
    chk("clr_valid", int'(bus.data_out_valid), 0);
    chk("clr_ready", int'(bus.data_in_ready), 1);
    chk_out("clr_keep_out", last_exp);
    run_group("clr_new", '{1, 0, 0, 0, 1, 8});

    fill(0, 7);
    bus.acc_len = CW'(5);
    send_beat();
    send_beat();
    send_beat();
    #2 rstn = 1'b0;
    #1;
    chk("arst_valid", int'(bus.data_out_valid), 0);
    chk("arst_ready", int'(bus.data_in_ready), 1);
    chk_out("arst_out", zero);
    @(negedge clk);
    rstn = 1'b1;
    step();
    run_group("arst_new", '{2, 1, 1, 1, 0, 0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
